// File: rtl/arbitro_memoria.sv
// arbitro_memoria: round-robin arbiter for the shared 8-bit memory/peripheral
// bus. Two requesters: the processor datapath (cpu) and the DMA/program-loader
// port (dma). An owner keeps the bus for up to MAX_BURST transfers and then
// yields if the other side is waiting. If nobody is waiting, it keeps the bus
// and starts a new burst count.
//
// Optional feature: define ARBITRO_TURNAROUND_EN to insert one dead cycle
// (TURN) after every release. In that cycle nobody is granted and the bus is
// driven to zero. Without the macro, a release hands the bus directly to the
// other requester if it is asking.
//
// Request/grant handshake: req_x acts as "valid" and gnt_x acts as "ready".
// A transfer happens in every cycle where both gnt_x and req_x are high.
// While req_x is high and gnt_x is low, the requester holds addr/wdata/write
// stable. A requester may drop req_x at any time; this cancels the request.
// gnt_x falls one edge after req_x drops. During that lag cycle write stays
// low because it is gated by req_x.
//
// The arbitration state is readable from the internal signals state,
// last_owner and burst_cnt.

module arbitro_memoria #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_cpu,
  input  logic [ADDR_W-1:0] addr_cpu,
  input  logic [DATA_W-1:0] wdata_cpu,
  input  logic              write_cpu,
  input  logic              req_dma,
  input  logic [ADDR_W-1:0] addr_dma,
  input  logic [DATA_W-1:0] wdata_dma,
  input  logic              write_dma,
  output logic              gnt_cpu,
  output logic              gnt_dma,
  output logic [ADDR_W-1:0] endereco_mem,
  output logic [DATA_W-1:0] dado_para_mem,
  output logic              write,
  output logic              ocupado
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

`ifdef ARBITRO_TURNAROUND_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2,
    ST_TURN = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_t;
`endif

  state_t           state;
  logic             last_owner;   // 0 = cpu, 1 = dma
  logic [CNT_W-1:0] burst_cnt;

  logic             own_req;
  logic             other_req;
  state_t           other_state;
  logic [CNT_W-1:0] cnt_inc;
  logic             burst_done;
  state_t           idle_next;
  state_t           rel_next;

  // Owner/other view of the requests; meaningful only in CPU/DMA states.
  always_comb begin
    own_req     = 1'b0;
    other_req   = 1'b0;
    other_state = ST_IDLE;
    case (state)
      ST_CPU: begin
        own_req     = req_cpu;
        other_req   = req_dma;
        other_state = ST_DMA;
      end
      ST_DMA: begin
        own_req     = req_dma;
        other_req   = req_cpu;
        other_state = ST_CPU;
      end
      default: begin
        own_req     = 1'b0;
        other_req   = 1'b0;
        other_state = ST_IDLE;
      end
    endcase
  end

  // Burst accounting: this cycle's transfer would be the last of the burst.
  always_comb begin
    cnt_inc    = burst_cnt + CNT_W'(1);
    burst_done = (cnt_inc == BURST_LAST);
  end

  // Arbitration from an ungranted state. On a tie, the requester that did not
  // own the bus last wins.
  always_comb begin
    idle_next = ST_IDLE;
    if (req_cpu && req_dma) begin
      idle_next = (last_owner == OWNER_DMA) ? ST_CPU : ST_DMA;
    end else if (req_cpu) begin
      idle_next = ST_CPU;
    end else if (req_dma) begin
      idle_next = ST_DMA;
    end
  end

  // Destination on release: a turnaround slot, or a direct handoff.
  always_comb begin
`ifdef ARBITRO_TURNAROUND_EN
    rel_next = ST_TURN;
`else
    rel_next = other_req ? other_state : ST_IDLE;
`endif
  end

  // Arbitration FSM: grant, burst counting, release and round-robin memory.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_owner <= OWNER_DMA;
      burst_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= idle_next;
        end
        ST_CPU, ST_DMA: begin
          if (!own_req || (burst_done && other_req)) begin
            state      <= rel_next;
            last_owner <= (state == ST_DMA) ? OWNER_DMA : OWNER_CPU;
            burst_cnt  <= '0;
          end else if (burst_done) begin
            burst_cnt <= '0;
          end else begin
            burst_cnt <= cnt_inc;
          end
        end
`ifdef ARBITRO_TURNAROUND_EN
        ST_TURN: begin
          state <= idle_next;
        end
`endif
        default: begin
          state     <= ST_IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  // Grants decode straight from the state register, so they are never both high.
  always_comb begin
    gnt_cpu = (state == ST_CPU);
    gnt_dma = (state == ST_DMA);
    ocupado = gnt_cpu | gnt_dma;
  end

  // Shared bus mux: the owner's signals drive the bus; otherwise it is zero.
  always_comb begin
    endereco_mem  = '0;
    dado_para_mem = '0;
    write         = 1'b0;
    if (gnt_cpu) begin
      endereco_mem  = addr_cpu;
      dado_para_mem = wdata_cpu;
      write         = req_cpu & write_cpu;
    end else if (gnt_dma) begin
      endereco_mem  = addr_dma;
      dado_para_mem = wdata_dma;
      write         = req_dma & write_dma;
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: bench for arbitro_memoria. Inputs are driven on the
// falling edge. Outputs are sampled 1 ns later in the same low phase.
// Expected bus/grant vectors are pushed to exp_q as stimulus is driven and
// popped when the cycle's outputs are sampled.
// Define ARBITRO_TURNAROUND_EN to build against the turnaround variant.

module tb_arbitro_memoria;

  logic       clock;
  logic       reset;
  logic       req_cpu, write_cpu, req_dma, write_dma;
  logic [7:0] addr_cpu, wdata_cpu, addr_dma, wdata_dma;
  logic       gnt_cpu, gnt_dma, write, ocupado;
  logic [7:0] endereco_mem, dado_para_mem;

  // {gnt_cpu, gnt_dma, ocupado, write, endereco_mem, dado_para_mem}
  logic [19:0] exp_q[$];
  logic [19:0] exp_v, obs_v;
  int checks = 0;
  int passed = 0;

  arbitro_memoria #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .req_cpu(req_cpu), .addr_cpu(addr_cpu), .wdata_cpu(wdata_cpu), .write_cpu(write_cpu),
    .req_dma(req_dma), .addr_dma(addr_dma), .wdata_dma(wdata_dma), .write_dma(write_dma),
    .gnt_cpu(gnt_cpu), .gnt_dma(gnt_dma), .endereco_mem(endereco_mem),
    .dado_para_mem(dado_para_mem), .write(write), .ocupado(ocupado)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] pack(input logic gc, input logic gd, input logic wr,
                                       input logic [7:0] a, input logic [7:0] d);
    return {gc, gd, gc | gd, wr, a, d};
  endfunction

  task automatic drive(input logic rc, input logic [7:0] ac, input logic [7:0] dc,
                       input logic wc, input logic rd, input logic [7:0] ad,
                       input logic [7:0] dd, input logic wd);
    req_cpu = rc; addr_cpu = ac; wdata_cpu = dc; write_cpu = wc;
    req_dma = rd; addr_dma = ad; wdata_dma = dd; write_dma = wd;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    drive(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Reset dominates even with both requests high; bus idle afterwards.
  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i < 2) begin
        reset = 1'b1;
        drive(1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1,
              1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1);
      end else begin
        reset = 1'b0;
        drive(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      end
      exp_q.push_back(pack(0, 0, 0, 8'h00, 8'h00));
      #1;
      exp_v = exp_q.pop_front();
      obs_v = {gnt_cpu, gnt_dma, ocupado, write, endereco_mem, dado_para_mem};
      checks++;
      if (obs_v !== exp_v) $display("FAIL reset cyc%0d: got %h expected %h", i, obs_v, exp_v);
      else passed++;
    end
  endtask

  // Single CPU write: one-edge grant latency, then release one edge after the drop.
  task automatic test_cpu_write;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      case (i)
        0: begin drive(1, 8'h10, 8'hA5, 1, 0, 8'h77, 8'h88, 1); exp_q.push_back(pack(0, 0, 0, 8'h00, 8'h00)); end
        1: begin drive(1, 8'h10, 8'hA5, 1, 0, 8'h77, 8'h88, 1); exp_q.push_back(pack(1, 0, 1, 8'h10, 8'hA5)); end
        2: begin drive(0, 8'h10, 8'hA5, 1, 0, 8'h77, 8'h88, 1); exp_q.push_back(pack(1, 0, 0, 8'h10, 8'hA5)); end
        default: begin drive(0, 8'h10, 8'hA5, 1, 0, 8'h77, 8'h88, 1); exp_q.push_back(pack(0, 0, 0, 8'h00, 8'h00)); end
      endcase
      #1;
      exp_v = exp_q.pop_front();
      obs_v = {gnt_cpu, gnt_dma, ocupado, write, endereco_mem, dado_para_mem};
      checks++;
      if (obs_v !== exp_v) $display("FAIL cpu_write cyc%0d: got %h expected %h", i, obs_v, exp_v);
      else passed++;
    end
  endtask

  // DMA alone for 10 granted cycles: the burst wraps without yielding.
  task automatic test_dma_long;
    logic [7:0] ad, dd;
    logic wd;
    do_reset();
    ad = 8'h40; dd = 8'h41; wd = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      if (i >= 1 && i <= 10) begin
        ad = 8'($urandom_range(0, 255));
        dd = 8'($urandom_range(0, 255));
        wd = 1'($urandom_range(0, 1));
      end
      if (i == 11) wd = 1'b1;
      drive(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1,
            (i <= 10), ad, dd, wd);
      if (i == 0 || i == 12) exp_q.push_back(pack(0, 0, 0, 8'h00, 8'h00));
      else if (i == 11)      exp_q.push_back(pack(0, 1, 0, ad, dd));
      else                   exp_q.push_back(pack(0, 1, wd, ad, dd));
      #1;
      exp_v = exp_q.pop_front();
      obs_v = {gnt_cpu, gnt_dma, ocupado, write, endereco_mem, dado_para_mem};
      checks++;
      if (obs_v !== exp_v) $display("FAIL dma_long cyc%0d: got %h expected %h", i, obs_v, exp_v);
      else passed++;
    end
  endtask

  // Both held: CPU wins the first tie, then 4-transfer blocks alternate.
  task automatic test_alternation;
    logic [7:0] ac, dc, ad, dd;
    logic wc, wd, none, own_cpu;
    do_reset();
    ac = 8'h01; dc = 8'h02; wc = 1'b0; ad = 8'h03; dd = 8'h04; wd = 1'b1;
    for (int i = 0; i <= 24; i++) begin
      @(negedge clock);
      none = (i == 0);
      own_cpu = 1'b0;
      if (i > 0) begin
`ifdef ARBITRO_TURNAROUND_EN
        none    = (((i - 1) % 5) == 4);
        own_cpu = ((((i - 1) / 5) % 2) == 0);
`else
        own_cpu = ((((i - 1) / 4) % 2) == 0);
`endif
      end
      // Only the granted side changes its signals; a waiting side holds them.
      if (!none && own_cpu) begin
        ac = 8'($urandom_range(0, 255)); dc = 8'($urandom_range(0, 255)); wc = 1'($urandom_range(0, 1));
      end else if (!none) begin
        ad = 8'($urandom_range(0, 255)); dd = 8'($urandom_range(0, 255)); wd = 1'($urandom_range(0, 1));
      end
      drive(1, ac, dc, wc, 1, ad, dd, wd);
      if (none)         exp_q.push_back(pack(0, 0, 0, 8'h00, 8'h00));
      else if (own_cpu) exp_q.push_back(pack(1, 0, wc, ac, dc));
      else              exp_q.push_back(pack(0, 1, wd, ad, dd));
      #1;
      exp_v = exp_q.pop_front();
      obs_v = {gnt_cpu, gnt_dma, ocupado, write, endereco_mem, dado_para_mem};
      checks++;
      if (obs_v !== exp_v) $display("FAIL alternate cyc%0d: got %h expected %h", i, obs_v, exp_v);
      else passed++;
    end
  endtask

  // Reset during the 2nd DMA transfer, then a tie goes to CPU; CPU drops
  // while DMA waits, so the bus is handed over.
  task automatic test_reset_mid_burst;
    int n;
`ifdef ARBITRO_TURNAROUND_EN
    n = 9;
`else
    n = 8;
`endif
    do_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = (i == 2);
      case (i)
        0: begin drive(0, 8'h00, 8'h00, 0, 1, 8'h33, 8'h44, 1); exp_q.push_back(pack(0, 0, 0, 8'h00, 8'h00)); end
        1: begin drive(0, 8'h00, 8'h00, 0, 1, 8'h33, 8'h44, 1); exp_q.push_back(pack(0, 1, 1, 8'h33, 8'h44)); end
        2: begin drive(0, 8'h00, 8'h00, 0, 1, 8'h34, 8'h45, 1); exp_q.push_back(pack(0, 1, 1, 8'h34, 8'h45)); end
        3: begin drive(1, 8'h55, 8'h66, 1, 1, 8'h34, 8'h45, 1); exp_q.push_back(pack(0, 0, 0, 8'h00, 8'h00)); end
        4: begin drive(1, 8'h55, 8'h66, 1, 1, 8'h34, 8'h45, 1); exp_q.push_back(pack(1, 0, 1, 8'h55, 8'h66)); end
        5: begin drive(0, 8'h55, 8'h66, 1, 1, 8'h34, 8'h45, 1); exp_q.push_back(pack(1, 0, 0, 8'h55, 8'h66)); end
`ifdef ARBITRO_TURNAROUND_EN
        6: begin drive(0, 8'h00, 8'h00, 0, 1, 8'h34, 8'h45, 1); exp_q.push_back(pack(0, 0, 0, 8'h00, 8'h00)); end
        7: begin drive(0, 8'h00, 8'h00, 0, 1, 8'h34, 8'h45, 0); exp_q.push_back(pack(0, 1, 0, 8'h34, 8'h45)); end
`else
        6: begin drive(0, 8'h00, 8'h00, 0, 1, 8'h34, 8'h45, 0); exp_q.push_back(pack(0, 1, 0, 8'h34, 8'h45)); end
`endif
        default: begin drive(0, 8'h00, 8'h00, 0, 1, 8'h35, 8'h46, 1); exp_q.push_back(pack(0, 1, 1, 8'h35, 8'h46)); end
      endcase
      #1;
      exp_v = exp_q.pop_front();
      obs_v = {gnt_cpu, gnt_dma, ocupado, write, endereco_mem, dado_para_mem};
      checks++;
      if (obs_v !== exp_v) $display("FAIL reset_mid cyc%0d: got %h expected %h", i, obs_v, exp_v);
      else passed++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    test_reset();
    test_cpu_write();
    test_dma_long();
    test_alternation();
    test_reset_mid_burst();
    do_reset();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
